codificador_rr: RTL and testbench

//  Parametrised, registered priority encoder: successor of the 8-to-3 combinational encoder.

---
 rtl/codificador_pkg.sv | 29 ++
 rtl/codificador_prio.sv | 26 ++
 rtl/codificador_rr.sv | 93 +++++++++
 tb/tb_codificador_rr.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared definitions for the codificador_rr registered priority encoder:
// mode selectors, FSM state encoding and a popcount helper.
package codificador_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Widest request vector the popcount helper handles; the top pads its
   // N-bit vector up to this width and keeps only the low W+1 count bits.
   localparam int MAX_N = 64;
   localparam int CNT_W = $clog2(MAX_N) + 1;

   // Two-state output FSM; FULL means a valid result is being presented.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Number of set bits in v (0..MAX_N).
   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_N-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int k = 0; k < MAX_N; k++) begin
         cnt = cnt + CNT_W'(v[k]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/codificador_prio.sv
// Combinational highest-index priority encoder: idx_o is the index of the
// most significant set bit of req_i, found_o flags that any bit was set.
module codificador_prio #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   // Ascending scan: later (higher) set bits overwrite earlier ones.
   always_comb begin
      // NOTE: defaults assigned before the loop so every path drives both
      // outputs; without them an all-zero req_i would infer latches.
      idx_o   = '0;
      found_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (req_i[k]) begin
            idx_o   = W'(k);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/codificador_rr.sv
// Registered N-bit priority encoder with optional round-robin arbitration,
// popcount of the captured vector and a ready/valid hold on the result.
// Supports N up to codificador_pkg::MAX_N.
module codificador_rr
   import codificador_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int RR = MODE_FIXED,
   localparam int W  = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i,
   input  logic         rdy,
   output logic [W-1:0] o,
   output logic         g,
   output logic [W:0]   n
);

   localparam logic [W:0] N_EXT = (W+1)'(N);

   state_e         state_q;
   logic [W-1:0]   o_q;
   logic [W:0]     n_q;
   logic [W-1:0]   l_q;

   logic [W-1:0]   rot_amt;
   logic [N-1:0]   rot_req;
   logic [W-1:0]   rot_idx;
   logic           rot_found;
   logic [W:0]     idx_sum;
   logic [W-1:0]   win_idx;
   logic           load;

   // Fixed mode never rotates; in round-robin the pointer L is the rotation.
   assign rot_amt = (RR == MODE_RR) ? l_q : '0;

   // Rotate right by L within N bits: rot_req[j] = i[(j+L) mod N], so bit
   // L-1 lands at the top and wins first. The doubled vector makes the wrap
   // modulo N even when N is not a power of two (L is always < N).
   assign rot_req = N'({i, i} >> rot_amt);

   codificador_prio #(
      .N (N)
   ) u_prio (
      .req_i   (rot_req),
      .idx_o   (rot_idx),
      .found_o (rot_found)
   );

   // Map the rotated index back to the original bit position, mod N.
   always_comb begin
      idx_sum = {1'b0, rot_idx} + {1'b0, rot_amt};
      if (idx_sum >= N_EXT) begin
         idx_sum = idx_sum - N_EXT;
      end
      win_idx = idx_sum[W-1:0];
   end

   // A new vector is captured whenever no result is pending or it is accepted.
   assign load = (state_q == ST_EMPTY) || rdy;

   // Output FSM with registered index, count and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here is a small control/data flop, so all of
      // them take the async reset; there is no memory array to leave unreset.
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         o_q     <= '0;
         n_q     <= '0;
         l_q     <= '0;
      end else if (load) begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would race with other readers.
         n_q <= (W+1)'(popcount(MAX_N'(i)));
         if (rot_found) begin
            state_q <= ST_FULL;
            o_q     <= win_idx;
            if (RR == MODE_RR) begin
               l_q <= win_idx;
            end
         end else begin
            state_q <= ST_EMPTY;
            o_q     <= '0;
         end
      end
   end

   assign o = o_q;
   assign g = (state_q == ST_FULL);
   assign n = n_q;

endmodule

// File: tb/tb_codificador_rr.sv
// Directed bench for codificador_rr: fixed priority (N=8), round-robin (N=8)
// and round-robin with a non-power-of-two width (N=5) side by side.
module tb_codificador_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rdy;
   logic [7:0] i8;
   logic [4:0] i5;

   logic [2:0] fx_o, rr_o, n5_o;
   logic       fx_g, rr_g, n5_g;
   logic [3:0] fx_n, rr_n, n5_n;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   codificador_rr #(.N(8), .RR(0)) dut_fx (
      .clk (clk), .rst_n (rst_n), .i (i8), .rdy (rdy),
      .o (fx_o), .g (fx_g), .n (fx_n)
   );

   codificador_rr #(.N(8), .RR(1)) dut_rr (
      .clk (clk), .rst_n (rst_n), .i (i8), .rdy (rdy),
      .o (rr_o), .g (rr_g), .n (rr_n)
   );

   codificador_rr #(.N(5), .RR(1)) dut_n5 (
      .clk (clk), .rst_n (rst_n), .i (i5), .rdy (rdy),
      .o (n5_o), .g (n5_g), .n (n5_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] exp_ff [8];

   initial begin
      // 1: reset asserted with all requests high
      rst_n = 1'b0;
      rdy   = 1'b1;
      i8    = 8'hFF;
      i5    = 5'b00000;
      #3;
      check("rst_o", fx_o, 0);
      check("rst_g", fx_g, 0);
      check("rst_n", fx_n, 0);
      #5 rst_n = 1'b1;
      tick();
      check("first_o", fx_o, 7);
      check("first_g", fx_g, 1);
      check("first_n", fx_n, 8);
      check("first_rr_o", rr_o, 7);

      // 2: fixed priority, one result per cycle
      i8 = 8'h00; tick();
      check("fx00_g", fx_g, 0);
      check("fx00_o", fx_o, 0);
      check("fx00_n", fx_n, 0);
      i8 = 8'h01; tick();
      check("fx01_o", fx_o, 0);
      check("fx01_g", fx_g, 1);
      check("fx01_n", fx_n, 1);
      i8 = 8'h11; tick();
      check("fx11_o", fx_o, 4);
      check("fx11_n", fx_n, 2);
      i8 = 8'h48; tick();
      check("fx48_o", fx_o, 6);
      check("fx48_n", fx_n, 2);
      i8 = 8'h25; tick();
      check("fx25_o", fx_o, 5);
      check("fx25_n", fx_n, 3);

      // 3: backpressure holds the result and ignores i
      i8 = 8'h11; tick();
      check("bp_cap_o", fx_o, 4);
      rdy = 1'b0;
      i8  = 8'h80;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_o", fx_o, 4);
         check("bp_hold_g", fx_g, 1);
         check("bp_hold_n", fx_n, 2);
      end
      rdy = 1'b1;
      tick();
      check("bp_rel_o", fx_o, 7);
      check("bp_rel_n", fx_n, 1);

      // 4: round-robin from a clean pointer (L=0)
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      i8 = 8'h81;
      tick(); check("rr81_a", rr_o, 7);
      tick(); check("rr81_b", rr_o, 0);
      tick(); check("rr81_c", rr_o, 7);
      tick(); check("rr81_d", rr_o, 0);
      // Last grant was 0, so L=0 and the search starts at N-1=7.
      exp_ff = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      i8 = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rrFF_o", rr_o, exp_ff[k]);
      end
      check("rrFF_n", rr_n, 8);

      // 5: reset in the middle of a hold
      i8 = 8'h08; tick();
      check("rr08_o", rr_o, 3);
      rdy = 1'b0;
      tick();
      check("hold_rr_g", rr_g, 1);
      check("hold_rr_o", rr_o, 3);
      rst_n = 1'b0;
      #2;
      check("midrst_g", rr_g, 0);
      check("midrst_o", rr_o, 0);
      check("midrst_n", rr_n, 0);
      rst_n = 1'b1;
      rdy = 1'b1;
      i8  = 8'h81;
      tick();
      check("postrst_o", rr_o, 7);

      // 6: N=5 round-robin wraps mod 5
      i5 = 5'b10001;
      tick();
      check("n5_a_o", n5_o, 4);
      check("n5_a_g", n5_g, 1);
      check("n5_a_n", n5_n, 2);
      tick(); check("n5_b_o", n5_o, 0);
      tick(); check("n5_c_o", n5_o, 4);
      i5 = 5'b00000;
      tick();
      check("n5_zero_g", n5_g, 0);
      check("n5_zero_o", n5_o, 0);
      check("n5_zero_n", n5_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
